rptr_handler: RTL and testbench

//  Read-side pointer/flag logic of the dual-clock FIFO; mirror of the write-side pointer handler.

---
 rtl/rptr_handler.sv | 79 +++++++
 tb/tb_rptr_handler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rptr_handler.sv
// Read-side pointer and status logic for a dual-clock FIFO (read clock domain).
// Optional sticky underflow detection is enabled by defining RPTR_UNDERFLOW_EN.
module rptr_handler #(
    parameter int ADDR_SIZE     = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic [ADDR_SIZE:0]   wptr_s,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rEmpty,
    output logic                 rAlmostEmpty,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 rUnderflow
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next;
    logic          accept;

    // A read is only accepted while the FIFO is non-empty; the pointer freezes otherwise.
    assign accept     = rinc & ~rEmpty;
    assign rbinnext   = rbin + {{ADDR_SIZE{1'b0}}, accept};
    assign rgraynext  = bin2gray(rbinnext);
    assign wbin_s     = gray2bin(wptr_s);
    assign level_next = wbin_s - rbinnext;
    assign raddr      = rbin[ADDR_SIZE-1:0];

    // Flags compare against the post-read pointer so they settle on the same edge as rptr.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin         <= '0;
            rptr         <= '0;
            rEmpty       <= 1'b1;
            rAlmostEmpty <= 1'b1;
            rlevel       <= '0;
        end else begin
            rbin         <= rbinnext;
            rptr         <= rgraynext;
            rEmpty       <= (rgraynext == wptr_s);
            rAlmostEmpty <= (level_next <= THRESH);
            rlevel       <= level_next;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rUnderflow <= 1'b0;
        end else if (rinc && rEmpty) begin
            rUnderflow <= 1'b1;
        end
    end
`else
    assign rUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_handler.sv
// Directed bench for rptr_handler: one instance at ADDR_SIZE=3, one at ADDR_SIZE=2.
module tb_rptr_handler;

`ifdef RPTR_UNDERFLOW_EN
    localparam logic UF_EN = 1'b1;
`else
    localparam logic UF_EN = 1'b0;
`endif

    logic       rclk;
    logic       rrst;
    logic       rinc_a, rinc_b;
    logic [3:0] wptr_a;
    logic [2:0] wptr_b;
    logic [2:0] raddr_a;
    logic [3:0] rptr_a, rlevel_a;
    logic       rempty_a, raempty_a, runder_a;
    logic [1:0] raddr_b;
    logic [2:0] rptr_b, rlevel_b;
    logic       rempty_b, raempty_b, runder_b;

    int tests = 0;
    int fails = 0;

    rptr_handler #(.ADDR_SIZE(3), .AEMPTY_THRESH(4)) dut_a (
        .rclk(rclk), .rrst(rrst), .rinc(rinc_a), .wptr_s(wptr_a),
        .raddr(raddr_a), .rptr(rptr_a), .rEmpty(rempty_a),
        .rAlmostEmpty(raempty_a), .rlevel(rlevel_a), .rUnderflow(runder_a)
    );

    rptr_handler #(.ADDR_SIZE(2), .AEMPTY_THRESH(4)) dut_b (
        .rclk(rclk), .rrst(rrst), .rinc(rinc_b), .wptr_s(wptr_b),
        .raddr(raddr_b), .rptr(rptr_b), .rEmpty(rempty_b),
        .rAlmostEmpty(raempty_b), .rlevel(rlevel_b), .rUnderflow(runder_b)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic pulse_reset();
        rrst = 1'b1;
        #1;
        rrst = 1'b0;
    endtask

    function automatic logic [2:0] g3(input int b);
        logic [2:0] x;
        x = 3'(b);
        return (x >> 1) ^ x;
    endfunction

    initial begin
        logic [2:0] prev;
        rrst   = 1'b1;
        rinc_a = 1'b0;
        rinc_b = 1'b0;
        wptr_a = 4'b0000;
        wptr_b = 3'b000;
        #12;
        check("rst_empty",  32'(rempty_a),  1);
        check("rst_aempty", 32'(raempty_a), 1);
        check("rst_rptr",   32'(rptr_a),    0);
        check("rst_raddr",  32'(raddr_a),   0);
        check("rst_level",  32'(rlevel_a),  0);
        check("rst_under",  32'(runder_a),  0);
        rrst = 1'b0;
        tick();
        check("idle_empty", 32'(rempty_a), 1);

        // write arrival: wptr Gray 0111 = binary 5
        wptr_a = 4'b0111;
        tick();
        check("arr_empty",  32'(rempty_a),  0);
        check("arr_level",  32'(rlevel_a),  5);
        check("arr_aempty", 32'(raempty_a), 0);
        rinc_a = 1'b1;
        tick();
        rinc_a = 1'b0;
        check("rd1_raddr",  32'(raddr_a),   1);
        check("rd1_rptr",   32'(rptr_a),    32'h1);
        check("rd1_level",  32'(rlevel_a),  4);
        check("rd1_aempty", 32'(raempty_a), 1);
        check("rd1_empty",  32'(rempty_a),  0);

        // reset asserted between edges with a read pending
        rinc_a = 1'b1;
        #2;
        rrst = 1'b1;
        #1;
        check("mid_rst_rptr",  32'(rptr_a),    0);
        check("mid_rst_raddr", 32'(raddr_a),   0);
        check("mid_rst_empty", 32'(rempty_a),  1);
        check("mid_rst_level", 32'(rlevel_a),  0);
        check("mid_rst_ae",    32'(raempty_a), 1);
        rrst   = 1'b0;
        rinc_a = 1'b0;
        wptr_a = 4'b0000;

        // drain to empty with a single entry, then keep reading
        wptr_a = 4'b0001;
        tick();
        check("dr_pre_empty", 32'(rempty_a), 0);
        check("dr_pre_level", 32'(rlevel_a), 1);
        rinc_a = 1'b1;
        tick();
        check("dr_raddr", 32'(raddr_a),  1);
        check("dr_empty", 32'(rempty_a), 1);
        check("dr_level", 32'(rlevel_a), 0);
        check("dr_under0", 32'(runder_a), 0);
        tick();
        check("dr_hold_raddr", 32'(raddr_a), 1);
        check("dr_hold_rptr",  32'(rptr_a),  32'h1);
        check("dr_under1",     32'(runder_a), 32'(UF_EN));
        tick();
        rinc_a = 1'b0;
        tick();
        check("dr_sticky", 32'(runder_a), 32'(UF_EN));
        check("dr_raddr2", 32'(raddr_a),  1);
        pulse_reset();
        check("dr_under_clr", 32'(runder_a), 0);

        // last entry read while a new write arrives on the same edge
        wptr_a = 4'b0001;
        tick();
        rinc_a = 1'b1;
        wptr_a = 4'b0011;
        tick();
        check("sim_empty", 32'(rempty_a), 0);
        check("sim_raddr", 32'(raddr_a),  1);
        check("sim_level", 32'(rlevel_a), 1);
        tick();
        rinc_a = 1'b0;
        check("sim2_raddr", 32'(raddr_a),  2);
        check("sim2_empty", 32'(rempty_a), 1);

        // wrap at ADDR_SIZE=2 with the writer one entry ahead
        pulse_reset();
        wptr_b = g3(1);
        tick();
        check("wr_start_empty", 32'(rempty_b), 0);
        prev = 3'b000;
        for (int i = 0; i < 8; i++) begin
            rinc_b = 1'b1;
            wptr_b = g3((i + 2) % 8);
            tick();
            check("wr_rptr",  32'(rptr_b), 32'(g3((i + 1) % 8)));
            check("wr_hamm",  32'($countones(rptr_b ^ prev)), 1);
            check("wr_level", 32'(rlevel_b), 1);
            prev = rptr_b;
        end
        rinc_b = 1'b0;
        check("wr_end_rptr",  32'(rptr_b),  0);
        check("wr_end_raddr", 32'(raddr_b), 0);

        // full FIFO at ADDR_SIZE=2 then drain
        pulse_reset();
        wptr_b = 3'b110;
        tick();
        check("full_level", 32'(rlevel_b),  4);
        check("full_empty", 32'(rempty_b),  0);
        check("full_ae",    32'(raempty_b), 1);
        rinc_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fd_level", 32'(rlevel_b), 32'(3 - k));
        end
        rinc_b = 1'b0;
        check("fd_rptr",  32'(rptr_b),   32'h6);
        check("fd_empty", 32'(rempty_b), 1);
        check("fd_raddr", 32'(raddr_b),  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
